ins_fetch_sequencer: RTL



---
 rtl/ins_fetch_sequencer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/ins_fetch_sequencer.sv
// ins_fetch_sequencer
//   Fetches instruction words from a byte-wide ROM. Each word takes four
//   byte reads at pc..pc+3. The bytes are assembled big-endian, so the lowest
//   address lands in bits [31:24]. Finished words go into a small prefetch
//   FIFO, which the core drains through a valid/ready handshake.
//   A redirect flushes everything and restarts fetch at a new address.
//   A misaligned or out-of-range fetch address stops issue and raises a
//   sticky fault.
//
// Ports
//   CLK, Reset         clock (rising edge), async active-high reset
//   rom_en/rom_addr    byte read strobe and byte address
//   rom_data           read byte, returned one cycle after its strobe
//   redirect_valid/addr  flush and restart fetch at redirect_addr
//   ins_valid/ready    FIFO head handshake
//   ins_data/ins_addr  head word and its byte address
//   fault_valid/code/addr  sticky fault (01 misaligned, 10 out of range)
module ins_fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned ROM_BYTES  = 100,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        Reset,
  output logic        rom_en,
  output logic [31:0] rom_addr,
  input  logic [7:0]  rom_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] ins_data,
  output logic [31:0] ins_addr,
  output logic        fault_valid,
  output logic [1:0]  fault_code,
  output logic [31:0] fault_addr
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [31:0] LAST_WORD = 32'(ROM_BYTES - 4);
  localparam logic [AW:0] DEPTH_C   = (AW+1)'(FIFO_DEPTH);

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_RANGE    = 2'b10;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] addr;
  } fetch_word_t;

  // ---------------------------------------------------------------- state
  logic [1:0]  state;
  logic [31:0] pc;        // address of the word being issued
  logic [1:0]  k;         // next byte index to issue within the word
  logic        cap_vld;   // a byte was issued last cycle; capture rom_data now
  logic [1:0]  cap_k;     // byte index of that capture
  logic [23:0] wbuf;      // upper three bytes of the word being assembled
  logic [31:0] waddr;     // address of the word being assembled

  fetch_word_t        mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        count;

  // ------------------------------------------------------------ decisions
  logic        word_start, misalign, out_of_range, pc_bad, slot_ok, issue;
  logic        push, pop;
  logic [AW:0] occ;

  // A new word may start only at a byte boundary of zero, outside FAULT.
  assign word_start   = (state != ST_FAULT) && (k == 2'd0);
  assign misalign     = (pc[1:0] != 2'b00);
  assign out_of_range = (pc > LAST_WORD);
  assign pc_bad       = misalign | out_of_range;

  // When k==0, a pending capture can only be byte 3 of the previous word.
  // That word still owns a FIFO slot until it is pushed, so it counts here.
  // This guarantees the FIFO never overflows.
  assign occ     = count + {{AW{1'b0}}, cap_vld};
  assign slot_ok = (occ < DEPTH_C);

  // Bytes 1..3 always follow byte 0 back to back. Only byte 0 is gated.
  // The Reset term keeps the strobe low while reset is held, because the
  // reset state is FETCH.
  assign issue = !Reset &&
                 (((state == ST_FETCH) && (k != 2'd0)) ||
                  (word_start && !pc_bad && slot_ok));

  assign rom_en   = issue;
  assign rom_addr = issue ? (pc + {30'd0, k}) : 32'd0;

  // A redirect drops the word completing this cycle.
  assign push = cap_vld && (cap_k == 2'd3) && !redirect_valid;
  assign pop  = ins_valid && ins_ready;

  assign ins_valid = (count != '0);
  assign ins_data  = ins_valid ? mem[rd_ptr].data : 32'd0;
  assign ins_addr  = ins_valid ? mem[rd_ptr].addr : 32'd0;

  // ------------------------------------------------------- fetch sequencer
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state       <= ST_FETCH;
      pc          <= RESET_PC;
      k           <= 2'd0;
      cap_vld     <= 1'b0;
      cap_k       <= 2'd0;
      waddr       <= 32'd0;
      fault_valid <= 1'b0;
      fault_code  <= 2'b00;
      fault_addr  <= 32'd0;
    end else if (redirect_valid) begin
      // Clearing cap_vld drops the byte that returns next cycle.
      state       <= ST_FETCH;
      pc          <= redirect_addr;
      k           <= 2'd0;
      cap_vld     <= 1'b0;
      fault_valid <= 1'b0;
      fault_code  <= 2'b00;
      fault_addr  <= 32'd0;
    end else begin
      cap_vld <= issue;
      cap_k   <= k;
      if (issue) begin
        state <= ST_FETCH;
        k     <= k + 2'd1;
        if (k == 2'd0) waddr <= pc;
        if (k == 2'd3) pc    <= pc + 32'd4;
      end else if (word_start && pc_bad) begin
        state       <= ST_FAULT;
        fault_valid <= 1'b1;
        fault_code  <= misalign ? FC_MISALIGN : FC_RANGE;
        fault_addr  <= pc;
      end else if (word_start) begin
        state <= ST_HOLD;
      end
    end
  end

  // ------------------------------------------------------------ assembly
  // Lanes fill from the top down. Byte 3 is not stored here; it goes
  // straight into the FIFO write together with wbuf.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      wbuf <= 24'd0;
    end else if (cap_vld) begin
      case (cap_k)
        2'd0:    wbuf[23:16] <= rom_data;
        2'd1:    wbuf[15:8]  <= rom_data;
        2'd2:    wbuf[7:0]   <= rom_data;
        default: ;
      endcase
    end
  end

  // ------------------------------------------------------- prefetch FIFO
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      // Any same-cycle transfer has already been seen by the consumer.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset. Reads are masked by ins_valid.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= '{data: {wbuf, rom_data}, addr: waddr};
  end

endmodule
